// File: rtl/key_onehot_debouncer.sv
// Four-key synchroniser/debouncer feeding a 4:2 encoder with a clean one-hot code and enable.
// An enable is only granted while exactly one key is stably pressed; multi-key presses lock out until all keys release.
module key_onehot_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic [3:0] onehot,
  output logic       en,
  output logic       press,
  output logic       multi_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_MULTI = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic is_multi(input logic [3:0] v);
    return (v != 4'd0) && !is_onehot(v);
  endfunction

  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       stable_q;
  logic [3:0]       stable_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  state_t           state_q;
  logic [3:0]       onehot_q;
  logic             en_q;
  logic             press_q;
  logic             multi_err_q;

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Synchroniser, debounce counters and stable levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 4'd0;
      sync2_q  <= 4'd0;
      stable_q <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= key;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Key-state FSM with outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      onehot_q    <= 4'd0;
      en_q        <= 1'b0;
      press_q     <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (is_onehot(stable_q)) begin
            state_q  <= S_HOLD;
            onehot_q <= stable_q;
            en_q     <= 1'b1;
            press_q  <= 1'b1;
          end else if (is_multi(stable_q)) begin
            state_q     <= S_MULTI;
            multi_err_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (stable_q == 4'd0) begin
            state_q  <= S_IDLE;
            onehot_q <= 4'd0;
            en_q     <= 1'b0;
          end else if (is_multi(stable_q)) begin
            state_q     <= S_MULTI;
            onehot_q    <= 4'd0;
            en_q        <= 1'b0;
            multi_err_q <= 1'b1;
          end else if (stable_q != onehot_q) begin
            // release of one key and press of another landed on the same edge
            onehot_q <= stable_q;
            press_q  <= 1'b1;
          end else begin
            state_q <= S_HOLD;
          end
        end
        S_MULTI: begin
          if (stable_q == 4'd0) begin
            state_q     <= S_IDLE;
            multi_err_q <= 1'b0;
          end else begin
            state_q <= S_MULTI;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          onehot_q    <= 4'd0;
          en_q        <= 1'b0;
          multi_err_q <= 1'b0;
        end
      endcase
    end
  end

  assign onehot    = onehot_q;
  assign en        = en_q;
  assign press     = press_q;
  assign multi_err = multi_err_q;

endmodule

// File: tb/tb_key_onehot_debouncer.sv
// Scoreboard bench for key_onehot_debouncer: a cycle model pushes expected outputs, a monitor pops and compares.
module tb_key_onehot_debouncer;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [3:0] key;
  logic [3:0] onehot;
  logic       en;
  logic       press;
  logic       multi_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] code;
    logic       en;
    logic       press;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  key_onehot_debouncer #(.DEBOUNCE_CYCLES(N), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .key(key),
    .onehot(onehot), .en(en), .press(press), .multi_err(multi_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each key's accepted level flips after N consecutive
  // disagreeing samples of the key as it was seen two edges earlier.
  logic [3:0] m_h1, m_h2, m_stable, m_code;
  int         m_run [4];
  int         m_state;   // 0 idle, 1 one key held, 2 multi lockout
  logic       m_press;

  task automatic model_step();
    int n;
    if (rst) begin
      m_h1 = 4'd0; m_h2 = 4'd0; m_stable = 4'd0; m_code = 4'd0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_state = 0; m_press = 1'b0;
    end else begin
      n = $countones(m_stable);
      m_press = 1'b0;
      case (m_state)
        0: if (n == 1) begin m_state = 1; m_press = 1'b1; end
           else if (n > 1) m_state = 2;
        1: if (n == 0) m_state = 0;
           else if (n > 1) m_state = 2;
           else if (m_stable != m_code) m_press = 1'b1;
        2: if (n == 0) m_state = 0;
        default: m_state = 0;
      endcase
      m_code = (m_state == 1) ? m_stable : 4'd0;
      for (int i = 0; i < 4; i++) begin
        if (m_h2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == N) begin
            m_stable[i] = m_h2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_h2 = m_h1;
      m_h1 = key;
    end
    exp_q.push_back('{code: m_code, en: (m_state == 1), press: m_press, err: (m_state == 2)});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: one expected record per edge, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_onehot", onehot, e.code);
        check("sb_en", {3'd0, en}, {3'd0, e.en});
        check("sb_press", {3'd0, press}, {3'd0, e.press});
        check("sb_multi_err", {3'd0, multi_err}, {3'd0, e.err});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts edges from the first one sampling the new input until en+press+code appear.
  task automatic measure(input logic [3:0] code, output int lat, output bit dropped);
    lat = 0;
    dropped = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (!en) dropped = 1'b1;
      if (lat == 0 && en && press && onehot == code) lat = k;
    end
  endtask

  initial begin
    int  lat;
    bit  dropped;
    int  mode, hold;
    logic [3:0] v;
    rst = 1'b1;
    key = 4'b0101;

    // reset held two cycles with keys asserted
    repeat (2) @(posedge clk);
    #1;
    check("t1_en_in_reset", {3'd0, en}, 4'd0);
    check("t1_onehot_in_reset", onehot, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    key = 4'b0000;
    cycles(10);

    // clean single press
    key = 4'b0010;
    measure(4'b0010, lat, dropped);
    check("t2_latency", 4'(lat), 4'd7);
    cycles(3);
    key = 4'b0000;
    cycles(12);

    // bouncing key, then held
    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      cycles(2);
    end
    key = 4'b0100;
    measure(4'b0100, lat, dropped);
    check("t3_latency_after_bounce", 4'(lat), 4'd7);
    cycles(2);
    key = 4'b0000;
    cycles(12);

    // direct jump between single keys keeps en high
    key = 4'b0001;
    cycles(12);
    key = 4'b1000;
    measure(4'b1000, lat, dropped);
    check("t4_jump_latency", 4'(lat), 4'd7);
    check("t4_en_dropped", {3'd0, dropped}, 4'd0);
    cycles(2);

    // multi-key lockout
    key = 4'b0001;
    cycles(12);
    key = 4'b0101;
    cycles(12);
    check("t5_multi_err", {3'd0, multi_err}, 4'd1);
    check("t5_en_off", {3'd0, en}, 4'd0);
    key = 4'b0001;
    cycles(12);
    check("t5_lockout_kept", {3'd0, multi_err}, 4'd1);
    check("t5_lockout_en", {3'd0, en}, 4'd0);
    key = 4'b0000;
    cycles(12);
    check("t5_released", {3'd0, multi_err}, 4'd0);

    // reset mid-press
    key = 4'b1000;
    cycles(12);
    check("t6_hold_before_rst", {3'd0, en}, 4'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_en_after_rst", {3'd0, en}, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    measure(4'b1000, lat, dropped);
    check("t6_relatch_latency", 4'(lat), 4'd7);
    cycles(2);

    // randomized key activity against the model
    for (int it = 0; it < 80; it++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: v = 4'(1 << $urandom_range(0, 3));
        1: v = 4'd0;
        default: v = 4'($urandom_range(0, 15));
      endcase
      hold = (mode == 3) ? $urandom_range(1, 3) : $urandom_range(1, 12);
      key = v;
      rst = ($urandom_range(0, 29) == 0);
      cycles(1);
      rst = 1'b0;
      cycles(hold);
    end
    key = 4'd0;
    cycles(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
